approx_prod_accum: RTL and testbench
====================================

// Module: approx_prod_accum
// PURPOSE
//  Downstream consumer of the 8x8 approximate multiplier (LUT2_1244 family).
//  Registers each 16-bit product, accumulates one vector's products into a
//  dot-product sum, and returns the sum over a valid/ready handshake.
//  Sits between the combinational multiplier and the error-metric/readout logic.
// PARAMETERS
//  PROD_W   16   product width (prod8 of the 8x8 multiplier)
//  ACC_W    24   accumulator / result width (ACC_W >= PROD_W)
//  MAX_LEN  256  max beats per vector; the beat that reaches it is a forced last
//  SAT      1    1 = saturate at 2^ACC_W-1; 0 = wrap modulo 2^ACC_W
// PORTS
//  clk       in   1                 rising-edge clock
//  rst       in   1                 async reset, active-high
//  in_valid  in   1                 product beat valid
//  in_ready  out  1                 block can accept a beat
//  in_prod   in   PROD_W            unsigned product from the multiplier
//  in_last   in   1                 beat is the last of the vector
//  out_valid out  1                 result valid
//  out_ready in   1                 consumer accepts result
//  out_sum   out  ACC_W             accumulated sum
//  out_len   out  $clog2(MAX_LEN+1) beats in this vector (1..MAX_LEN)
//  out_sat   out  1                 sum saturated (SAT=1) or wrapped (SAT=0)
//  out_trunc out  1                 vector ended by MAX_LEN, not by in_last
// BEHAVIOUR
//  - Reset: all outputs 0, in_ready 1, state IDLE; pipeline, acc, len and flags
//    cleared. Reset asserted mid-vector or mid-drain discards everything.
//  - Beat transfers when in_valid && in_ready. in_ready = (state != DRAIN) and
//    no last beat is pending in stage 1.
//  - Stage 1 (P): p_prod/p_last/p_vld <= accepted beat; p_last = in_last or
//    (len_cnt+1 == MAX_LEN). Stage 2 (A): acc <= acc + p_prod, zero-extended.
//  - States: IDLE (acc=0, len=0) -> ACC on first beat; ACC -> DRAIN when P holds
//    a last beat; DRAIN -> IDLE on out_valid && out_ready.
//  - Latency: last beat accepted at cycle t -> out_valid high at t+2, with
//    out_sum = sum of all beats incl. the last.
//  - out_valid held with sum/len/flags stable until out_ready; results are never
//    dropped. In DRAIN in_ready=0 even if out_ready=1 that cycle; next vector may
//    start the cycle after the result transfers (IDLE).
//  - Overflow: when acc+p_prod >= 2^ACC_W: SAT=1 -> acc = 2^ACC_W-1 (stays
//    clamped), out_sat=1; SAT=0 -> acc wraps, out_sat=1. Flag is sticky per vector.
//  - len_cnt counts accepted beats; forced last at MAX_LEN sets out_trunc=1;
//    in_last on that same beat clears out_trunc (normal end).
//  - Single-beat vector (in_last on first beat): out_sum = in_prod, out_len = 1.
//  - in_prod is sampled only on transfer; values while in_ready=0 are ignored.
// STRUCTURE
//  - Shared package approx_pkg: state enum {IDLE,ACC,DRAIN}, PROD_W/ACC_W
//    defaults, LEN_W function ($clog2(MAX_LEN+1)).
//  - One sub-module: acc_sat_add (ACC_W adder; inputs acc, addend, SAT;
//    outputs sum, ovf); purely combinational, reused by the error-metric block.
//  - Everything else (FSM, P stage, counters, output regs) in this module.
// TESTING
//  1 rst mid-vector after 3 beats -> all outputs 0, in_ready 1; next vector
//    {5,7} with last -> out_sum 12, out_len 2.
//  2 beats {0x00E1,0x0190,0x0051} (225,400,81), last on 3rd, out_ready=1 ->
//    out_valid 2 cycles after 3rd beat, out_sum 706, out_len 3, flags 0.
//  3 ACC_W=17, SAT=1: beats {0xFFFF,0xFFFF,0x0002} -> out_sum 0x1FFFF, out_sat 1;
//    SAT=0 -> out_sum 0x00000, out_sat 1.
//  4 MAX_LEN=4, 6 beats of 0x0010 no last -> result1 sum 0x40 len 4 trunc 1;
//    next vector starts with beats 5-6 and completes on a later last.
//  5 out_ready held 0 for 10 cycles -> out_valid/out_sum stable, in_ready 0, no
//    beats lost; release -> next vector {1} last -> out_sum 1, len 1.
//  6 random in_valid/out_ready gaps, 1000 vectors vs reference model of exact
//    sums with saturation -> zero mismatches.

Source files
------------

// File: rtl/approx_pkg.sv
// Shared definitions for the approximate-multiplier consumer blocks:
// accumulator state encoding, default widths and the length-counter width helper.
package approx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int PROD_W_DEF = 16;
  localparam int ACC_W_DEF  = 24;

  // Bits needed to hold a beat count in the range 0..max_len.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/acc_sat_add.sv
// Combinational ACC_W-bit adder with optional saturation.
// The addend is zero-extended; ovf flags a carry out of ACC_W bits, and with
// sat set the sum clamps to all ones instead of wrapping.
module acc_sat_add #(
  parameter int ACC_W  = 24,
  parameter int PROD_W = 16
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] addend,
  input  logic              sat,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic [ACC_W:0] full;

  // Wide add, then either clamp or wrap depending on the saturation mode.
  always_comb begin
    full = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, addend};
    ovf  = full[ACC_W];
    if (ovf && sat) begin
      sum = {ACC_W{1'b1}};
    end else begin
      sum = full[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/approx_prod_accum.sv
// Dot-product accumulator behind the 8x8 approximate multiplier.
// Beats are registered in a product stage (P), added into the accumulator (A),
// and the finished sum is held on a valid/ready output until taken.
// A vector ends on in_last or on the MAX_LEN-th beat (reported as truncated).
module approx_prod_accum
  import approx_pkg::*;
#(
  parameter int PROD_W  = PROD_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int MAX_LEN = 256,
  parameter int SAT     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PROD_W-1:0]           in_prod,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_W-1:0]            out_sum,
  output logic [len_w(MAX_LEN)-1:0]   out_len,
  output logic                        out_sat,
  output logic                        out_trunc
);

  localparam int LEN_W = len_w(MAX_LEN);

  state_t              state;
  logic                p_vld;
  logic                p_last;
  logic                p_trunc;
  logic [PROD_W-1:0]   p_prod;
  logic [ACC_W-1:0]    acc;
  logic [LEN_W-1:0]    len_cnt;
  logic                sat_flag;

  logic [LEN_W-1:0]    len_next;
  logic                at_max;
  logic                accept;
  logic [ACC_W-1:0]    add_sum;
  logic                add_ovf;

  acc_sat_add #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_add (
    .acc    (acc),
    .addend (p_prod),
    .sat    (SAT != 0),
    .sum    (add_sum),
    .ovf    (add_ovf)
  );

  // Handshake and length bookkeeping: stall while draining or while a last beat
  // is still waiting in P, so the vector boundary never mixes with the next one.
  always_comb begin
    len_next = len_cnt + LEN_W'(1);
    at_max   = (len_next == LEN_W'(MAX_LEN));
    in_ready = (state != DRAIN) && !(p_vld && p_last);
    accept   = in_valid && in_ready;
  end

  // Product stage, accumulator, FSM and registered result in one clocked block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      p_vld     <= 1'b0;
      p_last    <= 1'b0;
      p_trunc   <= 1'b0;
      p_prod    <= {PROD_W{1'b0}};
      acc       <= {ACC_W{1'b0}};
      len_cnt   <= {LEN_W{1'b0}};
      sat_flag  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= {ACC_W{1'b0}};
      out_len   <= {LEN_W{1'b0}};
      out_sat   <= 1'b0;
      out_trunc <= 1'b0;
    end else begin
      if (accept) begin
        p_vld   <= 1'b1;
        p_prod  <= in_prod;
        p_last  <= in_last || at_max;
        p_trunc <= !in_last && at_max;
        len_cnt <= len_next;
      end else begin
        p_vld   <= 1'b0;
        p_last  <= 1'b0;
        p_trunc <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state <= ACC;
          end else begin
            state <= IDLE;
          end
        end
        ACC: begin
          if (p_vld) begin
            acc      <= add_sum;
            sat_flag <= sat_flag || add_ovf;
            if (p_last) begin
              state     <= DRAIN;
              out_valid <= 1'b1;
              out_sum   <= add_sum;
              out_len   <= len_cnt;
              out_sat   <= sat_flag || add_ovf;
              out_trunc <= p_trunc;
            end else begin
              state <= ACC;
            end
          end else begin
            state <= ACC;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            acc       <= {ACC_W{1'b0}};
            len_cnt   <= {LEN_W{1'b0}};
            sat_flag  <= 1'b0;
          end else begin
            state <= DRAIN;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_approx_prod_accum.sv
// Directed and randomised checks of approx_prod_accum across four parameter sets:
// d0 default, d1 ACC_W=17 saturating, d2 ACC_W=17 wrapping, d3 MAX_LEN=4.
module tb_approx_prod_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_prod = 16'd0;
  logic        in_last = 1'b0;
  logic [3:0]  iv = 4'd0;
  logic [3:0]  ordy = 4'd0;
  logic [3:0]  ir, ov, osat, otrunc;
  logic [23:0] sum0, sum3;
  logic [16:0] sum1, sum2;
  logic [8:0]  len0, len1, len2;
  logic [2:0]  len3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  approx_prod_accum #(.ACC_W(24), .MAX_LEN(256), .SAT(1)) d0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_prod(in_prod),
    .in_last(in_last), .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(sum0),
    .out_len(len0), .out_sat(osat[0]), .out_trunc(otrunc[0]));
  approx_prod_accum #(.ACC_W(17), .MAX_LEN(256), .SAT(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_prod(in_prod),
    .in_last(in_last), .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(sum1),
    .out_len(len1), .out_sat(osat[1]), .out_trunc(otrunc[1]));
  approx_prod_accum #(.ACC_W(17), .MAX_LEN(256), .SAT(0)) d2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_prod(in_prod),
    .in_last(in_last), .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(sum2),
    .out_len(len2), .out_sat(osat[2]), .out_trunc(otrunc[2]));
  approx_prod_accum #(.ACC_W(24), .MAX_LEN(4), .SAT(1)) d3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_prod(in_prod),
    .in_last(in_last), .out_valid(ov[3]), .out_ready(ordy[3]), .out_sum(sum3),
    .out_len(len3), .out_sat(osat[3]), .out_trunc(otrunc[3]));

  function automatic logic [23:0] get_sum(input int d);
    case (d)
      0:       return sum0;
      1:       return {7'd0, sum1};
      2:       return {7'd0, sum2};
      default: return sum3;
    endcase
  endfunction

  function automatic int get_len(input int d);
    case (d)
      0:       return int'(len0);
      1:       return int'(len1);
      2:       return int'(len2);
      default: return int'(len3);
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one beat on DUT d (called at a negedge, returns at a negedge).
  task automatic send(input int d, input logic [15:0] p, input logic l, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    iv[d] = 1'b1;
    in_prod = p;
    in_last = l;
    n = 0;
    while (!ir[d] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!ir[d]) begin
      tests++;
      fails++;
      $display("FAIL send_timeout dut%0d: in_ready stayed 0 for %0d cycles", d, n);
    end
    @(negedge clk);
    iv[d] = 1'b0;
    in_last = 1'b0;
  endtask

  // Wait for and take one result from DUT d; rnd inserts random out_ready gaps.
  task automatic get_result(input int d, input logic [23:0] esum, input int elen,
                            input logic esat, input logic etrunc, input bit rnd,
                            input string name);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done) begin
      ordy[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ov[d] && ordy[d]) begin
        check(name, {get_sum(d), 8'(get_len(d)), 6'd0, osat[d], otrunc[d]},
              {esum, 8'(elen), 6'd0, esat, etrunc});
        done = 1'b1;
      end else if (n >= 400) begin
        tests++;
        fails++;
        $display("FAIL %s_timeout: out_valid never seen on dut%0d", name, d);
        done = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    ordy[d] = 1'b0;
  endtask

  typedef struct {
    int               d;
    int               n;
    logic [3:0][15:0] b;
    logic [23:0]      sum;
    int               len;
    logic             sat;
    logic             trunc;
  } vec_t;

  function automatic vec_t mk(input int d, input int n, input logic [15:0] b0,
                              input logic [15:0] b1, input logic [15:0] b2,
                              input logic [15:0] b3, input logic [23:0] s,
                              input int len, input logic sat, input logic trunc);
    vec_t v;
    v.d = d; v.n = n;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.sum = s; v.len = len; v.sat = sat; v.trunc = trunc;
    return v;
  endfunction

  vec_t tbl[10];
  int   exp_q[$];

  initial begin
    tbl[0] = mk(0, 3, 16'h00E1, 16'h0190, 16'h0051, 16'h0, 24'd706, 3, 1'b0, 1'b0);
    tbl[1] = mk(0, 2, 16'd5, 16'd7, 16'd0, 16'd0, 24'd12, 2, 1'b0, 1'b0);
    tbl[2] = mk(1, 3, 16'hFFFF, 16'hFFFF, 16'h0002, 16'h0, 24'h1FFFF, 3, 1'b1, 1'b0);
    tbl[3] = mk(2, 3, 16'hFFFF, 16'hFFFF, 16'h0002, 16'h0, 24'h00000, 3, 1'b1, 1'b0);
    tbl[4] = mk(0, 1, 16'd1, 16'd0, 16'd0, 16'd0, 24'd1, 1, 1'b0, 1'b0);
    tbl[5] = mk(1, 2, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 24'h1FFFE, 2, 1'b0, 1'b0);
    tbl[6] = mk(2, 1, 16'h1234, 16'h0, 16'h0, 16'h0, 24'h001234, 1, 1'b0, 1'b0);
    tbl[7] = mk(3, 3, 16'd1, 16'd2, 16'd3, 16'd0, 24'd6, 3, 1'b0, 1'b0);
    tbl[8] = mk(3, 4, 16'd1, 16'd2, 16'd3, 16'd4, 24'd10, 4, 1'b0, 1'b0);
    tbl[9] = mk(0, 4, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 24'h03FFFC, 4, 1'b0, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {ov, osat, otrunc, ir}, {4'b0000, 4'b0000, 4'b0000, 4'b1111});
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a vector discards it
    send(0, 16'd100, 1'b0, 0);
    send(0, 16'd200, 1'b0, 0);
    send(0, 16'd300, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midvec_reset", {get_sum(0), 8'(get_len(0)), 5'd0, ov[0], osat[0], otrunc[0], ir[0]},
          {24'd0, 8'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    rst = 1'b0;
    @(negedge clk);
    send(0, 16'd5, 1'b0, 0);
    send(0, 16'd7, 1'b1, 0);
    get_result(0, 24'd12, 2, 1'b0, 1'b0, 1'b0, "after_reset");

    // Latency: last beat accepted at cycle t, out_valid at t+2
    send(0, 16'h00E1, 1'b0, 0);
    send(0, 16'h0190, 1'b0, 0);
    send(0, 16'h0051, 1'b1, 0);
    check("latency_t1", {31'd0, ov[0]}, 32'd0);
    @(negedge clk);
    check("latency_t2", {31'd0, ov[0]}, 32'd1);
    get_result(0, 24'd706, 3, 1'b0, 1'b0, 1'b0, "latency_sum");

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        send(tbl[i].d, tbl[i].b[k], (k == tbl[i].n - 1), 0);
      end
      get_result(tbl[i].d, tbl[i].sum, tbl[i].len, tbl[i].sat, tbl[i].trunc, 1'b0,
                 $sformatf("vec%0d", i));
    end

    // MAX_LEN=4 forced last; beats 5-6 start the next vector
    fork
      begin
        for (int k = 0; k < 6; k++) send(3, 16'h0010, 1'b0, 0);
        send(3, 16'h0010, 1'b1, 0);
      end
      begin
        get_result(3, 24'h40, 4, 1'b0, 1'b1, 1'b0, "trunc_first");
        get_result(3, 24'h30, 3, 1'b0, 1'b0, 1'b0, "trunc_second");
      end
    join

    // Backpressure: result held for 10 cycles, pending beat not lost
    send(0, 16'd3, 1'b0, 0);
    send(0, 16'd4, 1'b1, 0);
    @(negedge clk);
    fork
      send(0, 16'd1, 1'b1, 0);
      begin
        for (int c = 0; c < 10; c++) begin
          check($sformatf("hold_c%0d", c), {get_sum(0), 6'd0, ov[0], ir[0]},
                {24'd7, 6'd0, 1'b1, 1'b0});
          @(negedge clk);
        end
        get_result(0, 24'd7, 2, 1'b0, 1'b0, 1'b0, "hold_release");
        get_result(0, 24'd1, 1, 1'b0, 1'b0, 1'b0, "after_hold");
      end
    join

    // Random gaps against a saturating reference model (ACC_W=17, SAT=1)
    fork
      begin
        for (int v = 0; v < 1000; v++) begin
          int nb;
          int total;
          logic [15:0] pv [5];
          nb = int'($urandom_range(1, 5));
          total = 0;
          for (int k = 0; k < nb; k++) begin
            pv[k] = 16'($urandom);
            total += int'(pv[k]);
          end
          exp_q.push_back(total);
          exp_q.push_back(nb);
          for (int k = 0; k < nb; k++) begin
            send(1, pv[k], (k == nb - 1), int'($urandom_range(0, 2)));
          end
        end
      end
      begin
        for (int v = 0; v < 1000; v++) begin
          int t;
          int nb;
          int w;
          w = 0;
          while (exp_q.size() < 2 && w < 2000) begin
            @(negedge clk);
            w++;
          end
          if (exp_q.size() < 2) begin
            tests++;
            fails++;
            $display("FAIL rand_queue_timeout: vector %0d never issued", v);
            break;
          end
          t = exp_q.pop_front();
          nb = exp_q.pop_front();
          get_result(1, (t >= 131072) ? 24'h1FFFF : 24'(t), nb, (t >= 131072), 1'b0,
                     1'b1, $sformatf("rand%0d", v));
        end
      end
    join

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
